router_pkt_tx: RTL
==================

Name: router_pkt_tx

Overview:
- Packet transmitter that drives the 1x3 router's input port.
- It buffers a payload from a local source, then emits one packet using the router's packet protocol: header, payload, parity.
- The header is {len[5:0], dest[1:0]}; pkt_valid is high for the header and payload bytes; the parity byte follows with pkt_valid low.
- The router's busy input stalls the block at any byte.
- It is the sending end of the interface whose receive side is the router FSM/sync/FIFO logic.

Parameters:
- MAX_LEN, 63: maximum payload bytes; also the payload buffer depth (1..63).
- IFG, 2: idle cycles forced between the end of the parity byte and the next packet (0..15).

Ports:
- clock  input  1  system clock; all logic samples on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to send a packet; sampled only in IDLE.
- dest  input  2  destination port, 0..2; 3 is illegal.
- len  input  6  payload length in bytes, 0..MAX_LEN.
- pl_data  input  8  payload byte from the source.
- pl_valid  input  1  pl_data is valid.
- pl_ready  output  1  block accepts pl_data this cycle.
- busy  input  1  router busy; holds the current byte.
- pkt_valid  output  1  router packet-valid.
- data_out  output  8  byte driven to the router's data_in.
- tx_active  output  1  high from LOAD through GAP.
- done  output  1  one-cycle pulse on GAP exit.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters, buffer pointers and the parity accumulator are cleared. Buffer contents are don't-care.
- Reset asserted in any state aborts the packet immediately; no parity byte is sent.
- A byte is "accepted" on a rising edge where it is driven and busy=0.
- While busy=1, data_out, pkt_valid and the state are held unchanged.

State machine:
- IDLE:
  - On start with dest!=3 and len<=MAX_LEN: latch dest and len, go to LOAD.
  - On start with dest==3 or len>MAX_LEN: pulse err next cycle, stay in IDLE.
  - start outside IDLE is ignored.
- LOAD:
  - pl_ready=1 while the number of bytes stored is less than len; the byte is written when pl_valid&pl_ready.
  - When the stored count equals len, go to HEADER on the next edge, with pl_ready=0.
  - If len==0, LOAD lasts 1 cycle.
- HEADER:
  - Drives pkt_valid=1, data_out={len,dest}; parity accumulator = header.
  - On accept: go to PAYLOAD, or to PARITY if len==0.
- PAYLOAD:
  - Drives pkt_valid=1, data_out = buffer[rd_ptr]; each accepted byte is XORed into parity and rd_ptr increments.
  - After the len-th byte is accepted, go to PARITY.
- PARITY:
  - Drives pkt_valid=0, data_out = parity (XOR of header and all payload bytes).
  - On accept, go to GAP.
- GAP:
  - Drives pkt_valid=0, data_out=0 for IFG cycles; busy is ignored.
  - Then pulse done and return to IDLE. With IFG=0, done pulses on the cycle after the parity byte is accepted.

Timing and buffer rules:
- No bubbles between header, payload and parity: the next byte is presented in the cycle immediately after an accept.
- The buffer is single-packet: rd_ptr and wr_ptr reset to 0 on entry to LOAD, so there is no wrap-around.
- tx_active=1 in every state except IDLE.

Optional Feature:
- Macro TX_PARITY_INJECT_EN adds an input port corrupt (1 bit), latched with start.
- When the latched corrupt=1, the transmitted parity byte is the true parity with bit 0 inverted; all other bytes are unchanged.
- Without the macro, the port does not exist and parity is always correct.

Test Plan:
- Basic packet: start with dest=1, len=3, payload A5,3C,FF, busy=0 → the router sees 0D,A5,3C,FF on consecutive cycles with pkt_valid=1, then 6B with pkt_valid=0. done pulses IFG=2 cycles after the parity byte is accepted.
- Busy stall: same packet with busy=1 for 3 cycles while A5 is presented → A5 is held 4 cycles, then 3C/FF/6B follow with no skip or duplicate; parity is still 6B.
- Zero length: dest=2, len=0 → header 02 (pkt_valid=1), then parity 02 (pkt_valid=0); pl_ready is never asserted.
- Illegal request: start with dest=3 → err pulses 1 cycle, tx_active stays 0, no bytes are emitted. A subsequent start with legal dest=0, len=63 sends header FC followed by 63 payload bytes in order, then the correct parity.
- Reset mid-operation: assert reset during PAYLOAD byte 2 → pkt_valid=0, data_out=00, tx_active=0 immediately (asynchronously). After release, a new packet sends correctly with parity computed from that packet only.
- With TX_PARITY_INJECT_EN: the basic packet with corrupt=1 → parity byte 6A; with corrupt=0 → 6B.

Source files
------------

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
//
// Packet transmitter that feeds the input port of the 1x3 router. A payload
// is first buffered from a local source, then one packet is sent as
// header {len, dest}, payload bytes and a trailing XOR parity byte.
// pkt_valid is high for the header and payload bytes and low for parity.
// The router's busy input holds whichever byte is being presented.
//
// Parameters:
//   MAX_LEN  maximum payload length, also the buffer depth (1..63)
//   IFG      idle cycles forced after the parity byte (0..15)
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   start      one-cycle send request (sampled in IDLE only)
//   dest       destination port 0..2 (3 is rejected)
//   len        payload length 0..MAX_LEN
//   pl_data    payload byte from the source
//   pl_valid   pl_data valid
//   pl_ready   payload byte accepted this cycle when pl_valid is high
//   busy       router busy, holds the current byte
//   pkt_valid  router packet-valid
//   data_out   byte to the router's data_in
//   tx_active  high in every state other than IDLE
//   done       one-cycle pulse when the inter-frame gap ends
//   err        one-cycle pulse when a request is rejected
//   corrupt    (TX_PARITY_INJECT_EN only) latched with start; inverts bit 0
//              of the transmitted parity byte
//
// Optional feature macro: TX_PARITY_INJECT_EN
// ---------------------------------------------------------------------------
module router_pkt_tx #(
  parameter int MAX_LEN = 63,
  parameter int IFG     = 2
) (
`ifdef TX_PARITY_INJECT_EN
  input  logic       corrupt,
`endif
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       err
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);
  // Value of gap_cnt in the final GAP cycle (unused when IFG is 0).
  localparam logic [3:0] IFG_LAST  = 4'(IFG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [1:0]  dest_reg;
  logic [5:0]  len_reg;
  logic [5:0]  wr_ptr;
  logic [5:0]  rd_ptr;
  logic [5:0]  rd_ptr_next;
  logic [7:0]  parity_reg;
  logic [7:0]  parity_out;
  logic [3:0]  gap_cnt;
  logic        done_reg;
  logic        err_reg;

  logic        start_ok;
  logic        load_full;
  logic        wr_en;
  logic        hdr_accept;
  logic        pl_accept;
  logic        par_accept;
  logic        gap_exit;
  logic [7:0]  header;

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    mem [0:MAX_LEN-1];
  logic [7:0]    rd_data;

`ifdef TX_PARITY_INJECT_EN
  logic        corrupt_reg;
  assign parity_out = parity_reg ^ {7'b0, corrupt_reg};
`else
  assign parity_out = parity_reg;
`endif

  assign start_ok  = start && (dest != 2'd3) && (len <= MAX_LEN_C);
  assign header    = {len_reg, dest_reg};
  assign load_full = (wr_ptr == len_reg);
  assign pl_ready  = (state_reg == S_LOAD) && !load_full;
  assign wr_en     = pl_ready && pl_valid;
  assign wr_addr   = wr_ptr[AW-1:0];
  assign done      = done_reg;
  assign err       = err_reg;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    pkt_valid   = 1'b0;
    data_out    = 8'h00;
    tx_active   = 1'b1;
    hdr_accept  = 1'b0;
    pl_accept   = 1'b0;
    par_accept  = 1'b0;
    gap_exit    = 1'b0;
    rd_ptr_next = rd_ptr;

    case (state_reg)
      S_IDLE: begin
        tx_active = 1'b0;
        if (start_ok) begin
          state_next  = S_LOAD;
          rd_ptr_next = 6'd0;
        end
      end

      S_LOAD: begin
        if (load_full) begin
          state_next = S_HEADER;
        end
      end

      S_HEADER: begin
        pkt_valid = 1'b1;
        data_out  = header;
        if (!busy) begin
          hdr_accept = 1'b1;
          state_next = (len_reg == 6'd0) ? S_PARITY : S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        pkt_valid = 1'b1;
        data_out  = rd_data;
        if (!busy) begin
          pl_accept   = 1'b1;
          rd_ptr_next = rd_ptr + 6'd1;
          if (rd_ptr == len_reg - 6'd1) begin
            state_next = S_PARITY;
          end
        end
      end

      S_PARITY: begin
        data_out = parity_out;
        if (!busy) begin
          par_accept = 1'b1;
          if (IFG == 0) begin
            state_next = S_IDLE;
            gap_exit   = 1'b1;
          end else begin
            state_next = S_GAP;
          end
        end
      end

      S_GAP: begin
        // busy is deliberately ignored here; the gap always runs IFG cycles.
        if (gap_cnt == IFG_LAST) begin
          state_next = S_IDLE;
          gap_exit   = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        tx_active  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Payload buffer. The read port is registered and addressed with the next
  // value of rd_ptr, so rd_data always equals mem[rd_ptr] one cycle later and
  // the payload streams with no bubble after each accept. The last increment
  // can point one past the buffer; that address is folded to 0 since the
  // value is never presented.
  // -------------------------------------------------------------------------
  assign rd_addr = (rd_ptr_next < MAX_LEN_C) ? rd_ptr_next[AW-1:0] : '0;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= pl_data;
    end
    rd_data <= mem[rd_addr];
  end

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      dest_reg   <= 2'd0;
      len_reg    <= 6'd0;
      wr_ptr     <= 6'd0;
      rd_ptr     <= 6'd0;
      parity_reg <= 8'h00;
      gap_cnt    <= 4'd0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
`ifdef TX_PARITY_INJECT_EN
      corrupt_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      rd_ptr    <= rd_ptr_next;
      done_reg  <= gap_exit;
      err_reg   <= (state_reg == S_IDLE) && start && !start_ok;

      if ((state_reg == S_IDLE) && start_ok) begin
        dest_reg   <= dest;
        len_reg    <= len;
        wr_ptr     <= 6'd0;
        parity_reg <= 8'h00;
`ifdef TX_PARITY_INJECT_EN
        corrupt_reg <= corrupt;
`endif
      end

      if (wr_en) begin
        wr_ptr <= wr_ptr + 6'd1;
      end

      // The accumulator restarts from the header, so an aborted packet never
      // leaks into the next one.
      if (hdr_accept) begin
        parity_reg <= header;
      end else if (pl_accept) begin
        parity_reg <= parity_reg ^ rd_data;
      end

      if (par_accept) begin
        gap_cnt <= 4'd0;
      end else if (state_reg == S_GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

endmodule
